// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: 11-bit frame receiver (start, 8 data LSB first, even parity, stop)
// with a two-flop input synchronizer, break detection and a single-entry
// output register with valid/acknowledge handshake and overrun flag.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       i_Clk,
    input  logic       i_RST,
    input  logic       i_Serial_In,
    input  logic       i_Data_Ack,
    output logic [7:0] o_Data_Out,
    output logic       o_Data_Valid,
    output logic       o_Parity_Err,
    output logic       o_Frame_Err,
    output logic       o_Overrun,
    output logic       o_RBusy
);

    localparam int unsigned    CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_Idle,
        S_Start,
        S_Data,
        S_Parity,
        S_Stop,
        S_Break
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_rx_d;
    logic [1:0]    r_settle;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_par;
    logic          r_stop;
    logic          r_done;

    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_perr;
    logic          r_ferr;
    logic          r_ovr;
    logic          r_busy;

    logic          w_rx_s;
    logic          w_cnt_full;
    logic          w_fall;

    assign w_rx_s     = r_sync2;
    assign w_cnt_full = (r_cnt == CNT_FULL);
    // The sync flops reset high, so an edge seen before the pipeline has
    // refilled with real line samples could be a reset artefact; start
    // detection waits until r_rx_d and w_rx_s both reflect the real line.
    assign w_fall     = (r_settle == 2'd3) && r_rx_d && !w_rx_s;

    // Input synchronizer, edge-detect history and post-reset settle counter
    always_ff @(posedge i_Clk) begin
        if (i_RST) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_rx_d   <= 1'b1;
            r_settle <= '0;
        end else begin
            r_sync1 <= i_Serial_In;
            r_sync2 <= r_sync1;
            r_rx_d  <= w_rx_s;
            if (r_settle != 2'd3) begin
                r_settle <= r_settle + 2'd1;
            end
        end
    end

    // Receive FSM, bit timing and registered output/handshake logic
    always_ff @(posedge i_Clk) begin
        if (i_RST) begin
            r_state <= S_Idle;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_stop  <= 1'b1;
            r_done  <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_Idle: begin
                    r_cnt <= '0;
                    if (w_fall) begin
                        r_state <= S_Start;
                        r_busy  <= 1'b1;
                    end
                end
                S_Start: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state <= S_Data;
                            r_bit   <= '0;
                        end else begin
                            r_state <= S_Idle;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_Data: begin
                    if (w_cnt_full) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            r_state <= S_Parity;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_Parity: begin
                    if (w_cnt_full) begin
                        r_cnt   <= '0;
                        r_par   <= w_rx_s;
                        r_state <= S_Stop;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_Stop: begin
                    if (w_cnt_full) begin
                        r_cnt  <= '0;
                        r_stop <= w_rx_s;
                        r_done <= 1'b1;
                        if (w_rx_s) begin
                            r_state <= S_Idle;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_Break;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_Break: begin
                    r_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= S_Idle;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_Idle;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase

            // Completed byte has priority; a same-cycle ack only suppresses overrun
            if (r_done) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                r_perr  <= (^r_shift) ^ r_par;
                r_ferr  <= ~r_stop;
                r_ovr   <= r_valid & ~i_Data_Ack;
            end else if (r_valid && i_Data_Ack) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end
        end
    end

    assign o_Data_Out   = r_data;
    assign o_Data_Valid = r_valid;
    assign o_Parity_Err = r_perr;
    assign o_Frame_Err  = r_ferr;
    assign o_Overrun    = r_ovr;
    assign o_RBusy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// tb_uart_rx: directed-frame bench for uart_rx with hand-computed expectations.
module tb_uart_rx;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] dout;
    logic       valid;
    logic       perr;
    logic       ferr;
    logic       ovr;
    logic       busy;

    int unsigned cyc     = 0;
    int unsigned t_start = 0;
    int          n_cmp   = 0;
    int          n_err   = 0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clk        (clk),
        .i_RST        (rst),
        .i_Serial_In  (rx),
        .i_Data_Ack   (ack),
        .o_Data_Out   (dout),
        .o_Data_Valid (valid),
        .o_Parity_Err (perr),
        .o_Frame_Err  (ferr),
        .o_Overrun    (ovr),
        .o_RBusy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // t_start = posedge at which the start-bit falling edge is captured
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        @(negedge clk);
        for (int unsigned i = 0; i < 11; i++) begin
            rx = bits[i];
            if (i == 0) t_start = cyc + 1;
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        // reset state
        tick(4);
        rst = 1'b0;
        tick(5);
        chk("rst_dout",  32'(dout),  32'h00);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_perr",  32'(perr),  32'h0);
        chk("rst_ferr",  32'(ferr),  32'h0);
        chk("rst_ovr",   32'(ovr),   32'h0);
        chk("rst_busy",  32'(busy),  32'h0);

        // clean byte 0xA5 with latency check
        fork
            send_frame(8'hA5, 1'b0, 1'b1);
            begin
                tick(2);
                while (cyc < t_start + 50) @(negedge clk);
                chk("a5_busy_mid", 32'(busy), 32'h1);
                while (cyc < t_start + 170) @(negedge clk);
                chk("a5_valid_t170", 32'(valid), 32'h0);
                @(negedge clk);
                chk("a5_valid_t171", 32'(valid), 32'h1);
            end
        join
        chk("a5_dout", 32'(dout), 32'hA5);
        chk("a5_perr", 32'(perr), 32'h0);
        chk("a5_ferr", 32'(ferr), 32'h0);
        chk("a5_busy", 32'(busy), 32'h0);
        do_ack();
        chk("a5_ack_valid", 32'(valid), 32'h0);
        chk("a5_ack_dout",  32'(dout),  32'hA5);

        // parity error: 0x07 has odd ones count, parity bit sent as 0
        send_frame(8'h07, 1'b0, 1'b1);
        chk("p07_dout",  32'(dout),  32'h07);
        chk("p07_perr",  32'(perr),  32'h1);
        chk("p07_ferr",  32'(ferr),  32'h0);
        chk("p07_valid", 32'(valid), 32'h1);
        do_ack();
        chk("p07_ack_perr", 32'(perr), 32'h1);

        // 4-cycle glitch
        @(negedge clk);
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        chk("glitch_busy_in", 32'(busy), 32'h1);
        tick(30);
        chk("glitch_busy_out", 32'(busy),  32'h0);
        chk("glitch_valid",    32'(valid), 32'h0);

        // framing error followed by break
        send_frame(8'h3C, 1'b0, 1'b0);
        tick(40);
        chk("brk_dout",  32'(dout),  32'h3C);
        chk("brk_ferr",  32'(ferr),  32'h1);
        chk("brk_perr",  32'(perr),  32'h0);
        chk("brk_valid", 32'(valid), 32'h1);
        chk("brk_busy",  32'(busy),  32'h1);
        rx = 1'b1;
        tick(5);
        chk("brk_busy_end", 32'(busy), 32'h0);
        do_ack();

        // overrun
        send_frame(8'h11, 1'b0, 1'b1);
        chk("ov_first_ovr", 32'(ovr), 32'h0);
        send_frame(8'h22, 1'b0, 1'b1);
        chk("ov_dout",  32'(dout),  32'h22);
        chk("ov_ovr",   32'(ovr),   32'h1);
        chk("ov_valid", 32'(valid), 32'h1);
        chk("ov_ferr",  32'(ferr),  32'h0);
        do_ack();
        chk("ov_ack_valid", 32'(valid), 32'h0);
        chk("ov_ack_ovr",   32'(ovr),   32'h0);
        chk("ov_ack_dout",  32'(dout),  32'h22);

        // ack on the completion cycle of the next byte
        send_frame(8'h55, 1'b0, 1'b1);
        chk("col_55_valid", 32'(valid), 32'h1);
        fork
            send_frame(8'hAA, 1'b0, 1'b1);
            begin
                tick(2);
                while (cyc < t_start + 170) @(negedge clk);
                ack = 1'b1;
                @(negedge clk);
                ack = 1'b0;
            end
        join
        chk("col_dout",  32'(dout),  32'hAA);
        chk("col_valid", 32'(valid), 32'h1);
        chk("col_ovr",   32'(ovr),   32'h0);
        chk("col_perr",  32'(perr),  32'h0);
        do_ack();

        // reset after 4 data bits of 0xC3, line low at release
        @(negedge clk);
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1; tick(CPB);
        rx = 1'b1; tick(CPB);
        rx = 1'b0; tick(CPB);
        rx = 1'b0; tick(CPB);
        chk("mid_busy_pre", 32'(busy), 32'h1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(40);
        chk("mid_dout",  32'(dout),  32'h00);
        chk("mid_valid", 32'(valid), 32'h0);
        chk("mid_busy",  32'(busy),  32'h0);
        chk("mid_ferr",  32'(ferr),  32'h0);
        chk("mid_ovr",   32'(ovr),   32'h0);
        rx = 1'b1;
        tick(20);
        chk("mid_busy_high",  32'(busy),  32'h0);
        chk("mid_valid_high", 32'(valid), 32'h0);
        send_frame(8'hC3, 1'b0, 1'b1);
        chk("c3_dout",  32'(dout),  32'hC3);
        chk("c3_valid", 32'(valid), 32'h1);
        chk("c3_perr",  32'(perr),  32'h0);
        chk("c3_ferr",  32'(ferr),  32'h0);
        chk("c3_ovr",   32'(ovr),   32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
